// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock behind valid/ready handshakes.
// Define SEQ_SHIFTER_ROTATE_EN to enable the rotate (rot) operation.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             lr,
  input  logic             al,
  input  logic             rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   cnt_q;
  logic             lr_q;
  logic             al_q;
  logic             accept;
  logic             fill_l;
  logic             fill_r;
  logic [WIDTH-1:0] step_data;

`ifdef SEQ_SHIFTER_ROTATE_EN
  logic rot_q;
`else
  logic unused_rot;
  assign unused_rot = rot;
`endif

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign dout     = data_q;

  // One-position step of the working register; the fill bit picks the operation.
  always_comb begin
    fill_l = 1'b0;
    fill_r = al_q & data_q[WIDTH-1];
`ifdef SEQ_SHIFTER_ROTATE_EN
    if (rot_q) begin
      fill_l = data_q[WIDTH-1];
      fill_r = data_q[0];
    end
`endif
    if (lr_q)
      step_data = {data_q[WIDTH-2:0], fill_l};
    else
      step_data = {fill_r, data_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      lr_q      <= 1'b0;
      al_q      <= 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot_q     <= 1'b0;
`endif
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            data_q <= din;
            cnt_q  <= shamt;
            lr_q   <= lr;
            al_q   <= al;
`ifdef SEQ_SHIFTER_ROTATE_EN
            rot_q  <= rot;
`endif
            busy   <= 1'b1;
            // A zero shift amount skips SHIFT so the result appears one cycle later.
            if (shamt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state     <= SHIFT;
              out_valid <= 1'b0;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        SHIFT: begin
          data_q <= step_data;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_seq_shifter;

`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] shamt;
  logic       lr;
  logic       al;
  logic       rot;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seq_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .shamt(shamt), .lr(lr), .al(al), .rot(rot),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result computed directly from the operation definition.
  function automatic logic [7:0] refShift(input logic [7:0] d, input int s,
                                          input bit l, input bit a, input bit r);
    logic [15:0]       twice;
    logic [15:0]       wide;
    logic signed [7:0] sd;
    twice = {d, d};
    if (r && ROT_EN) begin
      if (l) begin
        wide = twice << s;
        return wide[15:8];
      end
      wide = twice >> s;
      return wide[7:0];
    end
    if (l) begin
      wide = {8'h00, d} << s;
      return wide[7:0];
    end
    if (a) begin
      sd = d;
      return 8'(sd >>> s);
    end
    return d >> s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, verify latency and result, apply `hold` cycles of backpressure, then consume.
  task automatic applyStimulus(input logic [7:0] d, input int s, input bit l, input bit a,
                               input bit r, input int hold);
    int         cycles;
    logic [7:0] exp;
    logic [7:0] held;
    exp    = refShift(d, s, l, a, r);
    cycles = 0;
    while (!in_ready && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("in_ready_before_accept", in_ready, 1);
    din = d; shamt = 3'(s); lr = l; al = a; rot = r;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    din = 8'($urandom); shamt = 3'($urandom); lr = 1'($urandom); al = 1'($urandom); rot = 1'($urandom);
    cycles = 1;
    checkOutput("busy_after_accept", busy, 1);
    if (s != 0) checkOutput("in_ready_during_shift", in_ready, 0);
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("latency", cycles, s + 1);
    checkOutput("result", dout, exp);
    held = dout;
    repeat (hold) begin
      @(posedge clk); #1;
      checkOutput("stable_dout", dout, held);
      checkOutput("in_ready_backpressure", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("valid_after_consume", out_valid, 0);
    checkOutput("busy_after_consume", busy, 0);
  endtask

  initial begin
    logic [7:0] held;
    logic [7:0] exp;
    int         cycles;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    din = '0; shamt = '0; lr = 1'b0; al = 1'b0; rot = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_dout", dout, 8'h00);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_busy", busy, 0);

    $display("[TB] directed shifts");
    applyStimulus(8'h96, 3, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(8'h96, 3, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(8'h96, 3, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(8'h96, 0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(8'h96, 7, 1'b0, 1'b1, 1'b0, 0);

    $display("[TB] backpressure and back-to-back");
    din = 8'h96; shamt = 3'd2; lr = 1'b0; al = 1'b1; rot = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("bp_latency", cycles, 3);
    checkOutput("bp_result", dout, refShift(8'h96, 2, 1'b0, 1'b1, 1'b0));
    held = dout;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("bp_stable_dout", dout, held);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
    end
    din = 8'h81; shamt = 3'd1; lr = 1'b0; al = 1'b1; rot = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 checkOutput("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("b2b_busy", busy, 1);
    checkOutput("b2b_no_valid", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("b2b_valid", out_valid, 1);
    checkOutput("b2b_result", dout, refShift(8'h81, 1, 1'b0, 1'b1, 1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    $display("[TB] reset mid-shift");
    din = 8'($urandom); shamt = 3'd7; lr = 1'b0; al = 1'b1; rot = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_dout", dout, 8'h00);
    checkOutput("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("postrst_in_ready", in_ready, 1);
    checkOutput("postrst_out_valid", out_valid, 0);
    applyStimulus(8'h3C, 5, 1'b1, 1'b0, 1'b0, 1);

    $display("[TB] rotate requests");
    applyStimulus(8'h96, 3, 1'b0, 1'b0, 1'b1, 0);
    applyStimulus(8'h96, 3, 1'b1, 1'b0, 1'b1, 0);
    applyStimulus(8'h96, 2, 1'b0, 1'b1, 1'b1, 0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 30; i++) begin
      exp = 8'($urandom_range(0, 255));
      applyStimulus(exp, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
